// File: rtl/vgac_param.sv
// Parametrised VGA timing controller with framebuffer fetch and test patterns.
// Counters feed stage 1 (addresses, read strobe, delayed timing flags), which
// feeds stage 2 (pins). Sync, data enable and colour all leave two cycles after
// the counters, so they stay aligned on the connector.
module vgac_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 4,
  parameter int AW       = 10
) (
  input  logic            vga_clk,
  input  logic            clrn,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] fill,
  input  logic [3*CW-1:0] d_in,
  output logic [AW-1:0]   row_addr,
  output logic [AW-1:0]   col_addr,
  output logic            rdn,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b,
  output logic            hs,
  output logic            vs,
  output logic            de,
  output logic            frame_start,
  output logic            line_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_OFF   = H_SYNC + H_BP;
  localparam int V_OFF   = V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  // Counters and the per-frame mode latch
  logic [AW-1:0] h_cnt_q, h_cnt_d;
  logic [AW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    mode_q, mode_d;

  // Stage 1
  logic [AW-1:0] col_q, col_d;
  logic [AW-1:0] row_q, row_d;
  logic          rdn_q, rdn_d;
  logic          act1_q, act1_d;
  logic          hs1_q, hs1_d;
  logic          vs1_q, vs1_d;
  logic          fs1_q, fs1_d;
  logic          ls1_q, ls1_d;
  logic [1:0]    mode1_q, mode1_d;

  // Stage 2 (pins)
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            de_q, de_d;
  logic            fs_q, fs_d;
  logic            ls_q, ls_d;
  logic [3*CW-1:0] rgb_q, rgb_d;

  logic          h_wrap;
  logic          at_origin;
  logic          active;
  logic [1:0]    mode_eff;
  logic [7:1]    bar_ge;
  logic [2:0]    bar_idx;
  logic          grid_on;
  logic [3*CW-1:0] src;

  // Bar boundaries: one comparator per bar edge, index = number of edges passed
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar
    assign bar_ge[gi] = (col_q >= AW'(gi * BAR_W));
  end
  assign bar_idx = 3'($countones(bar_ge));

  // Counter advance, mode latch and stage-1 next state
  always_comb begin
    h_wrap    = (h_cnt_q == AW'(H_TOTAL - 1));
    at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_cnt_d   = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d   = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == AW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
    end
    // The new mode governs the frame starting at the origin, including that pixel
    mode_eff = at_origin ? mode : mode_q;
    mode_d   = mode_eff;
    active   = (h_cnt_q >= AW'(H_OFF)) && (h_cnt_q < AW'(H_OFF + H_ACTIVE)) &&
               (v_cnt_q >= AW'(V_OFF)) && (v_cnt_q < AW'(V_OFF + V_ACTIVE));
    col_d    = h_cnt_q - AW'(H_OFF);
    row_d    = v_cnt_q - AW'(V_OFF);
    rdn_d    = !(active && (mode_eff == 2'd0));
    act1_d   = active;
    hs1_d    = (h_cnt_q < AW'(H_SYNC)) ? HS_POL : ~HS_POL;
    vs1_d    = (v_cnt_q < AW'(V_SYNC)) ? VS_POL : ~VS_POL;
    fs1_d    = at_origin;
    ls1_d    = active && (h_cnt_q == AW'(H_OFF));
    mode1_d  = mode_eff;
  end

  // Pixel source selection and stage-2 next state
  always_comb begin
    grid_on = (col_q[3:0] == 4'd0) || (row_q[3:0] == 4'd0) ||
              (col_q == AW'(H_ACTIVE - 1)) || (row_q == AW'(V_ACTIVE - 1));
    case (mode1_q)
      2'd0:    src = d_in;
      // Bar colour bits: b = ~idx[0], g = ~idx[2], r = ~idx[1]
      2'd1:    src = {{CW{~bar_idx[0]}}, {CW{~bar_idx[2]}}, {CW{~bar_idx[1]}}};
      2'd2:    src = {(3*CW){grid_on}};
      default: src = fill;
    endcase
    rgb_d = act1_q ? src : '0;
    hs_d  = hs1_q;
    vs_d  = vs1_q;
    de_d  = act1_q;
    fs_d  = fs1_q;
    ls_d  = ls1_q;
  end

  // All state registers with synchronous active-low reset
  always_ff @(posedge vga_clk) begin
    if (!clrn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= 2'd0;
      col_q   <= '0;
      row_q   <= '0;
      rdn_q   <= 1'b1;
      act1_q  <= 1'b0;
      hs1_q   <= ~HS_POL;
      vs1_q   <= ~VS_POL;
      fs1_q   <= 1'b0;
      ls1_q   <= 1'b0;
      mode1_q <= 2'd0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rdn_q   <= rdn_d;
      act1_q  <= act1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      fs1_q   <= fs1_d;
      ls1_q   <= ls1_d;
      mode1_q <= mode1_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      rgb_q   <= rgb_d;
    end
  end

  assign col_addr    = col_q;
  assign row_addr    = row_q;
  assign rdn         = rdn_q;
  assign r           = rgb_q[CW-1:0];
  assign g           = rgb_q[2*CW-1:CW];
  assign b           = rgb_q[3*CW-1:2*CW];
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vgac_param.sv
// Directed bench for vgac_param using two reduced video modes: an active-low
// mode (48x32 total, 32x24 visible) and an active-high mode (25x14 total).
module tb_vgac_param;

  localparam int FRAME   = 48 * 32;
  localparam int FRAME_B = 25 * 14;

  logic clk;
  logic clrn;

  // Instance A: active-low sync
  logic [1:0]  mode_a;
  logic [11:0] fill_a;
  logic [11:0] d_in_a;
  logic [7:0]  row_a, col_a;
  logic        rdn_a;
  logic [3:0]  r_a, g_a, b_a;
  logic        hs_a, vs_a, de_a, fs_a, ls_a;

  // Instance B: active-high sync
  logic [1:0]  mode_b;
  logic [11:0] fill_b;
  logic [11:0] d_in_b;
  logic [4:0]  row_b, col_b;
  logic        rdn_b;
  logic [3:0]  r_b, g_b, b_b;
  logic        hs_b, vs_b, de_b, fs_b, ls_b;

  int compared = 0;
  int mism     = 0;

  logic [11:0] cap_rgb [FRAME];
  logic [7:0]  cap_col [FRAME];
  logic [7:0]  cap_row [FRAME];
  logic        cap_rdn [FRAME];
  logic        cap_hs  [FRAME];
  logic        cap_vs  [FRAME];
  logic        cap_de  [FRAME];
  logic        cap_fs  [FRAME];
  logic        cap_ls  [FRAME];

  int n_hs_lo, n_vs_lo, n_de, n_ls, n_fs, n_rdn_lo;
  int steps;
  int bh, bv, bd, bl;

  assign d_in_a = {col_a[3:0], row_a[3:0], col_a[3:0]};

  vgac_param #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .AW(8)
  ) dut_a (
    .vga_clk(clk), .clrn(clrn), .mode(mode_a), .fill(fill_a), .d_in(d_in_a),
    .row_addr(row_a), .col_addr(col_a), .rdn(rdn_a),
    .r(r_a), .g(g_a), .b(b_a), .hs(hs_a), .vs(vs_a), .de(de_a),
    .frame_start(fs_a), .line_start(ls_a)
  );

  vgac_param #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .AW(5)
  ) dut_b (
    .vga_clk(clk), .clrn(clrn), .mode(mode_b), .fill(fill_b), .d_in(d_in_b),
    .row_addr(row_b), .col_addr(col_b), .rdn(rdn_b),
    .r(r_b), .g(g_b), .b(b_b), .hs(hs_b), .vs(vs_b), .de(de_b),
    .frame_start(fs_b), .line_start(ls_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Step negedges until frame_start of instance A is seen, within a budget
  task automatic wait_fs(input int budget, output int n);
    n = 0;
    while (fs_a !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("fs_seen", 32'(fs_a), 32'd1);
  endtask

  // Record one frame of instance A starting at stage-2 index 0; optionally
  // change the mode input at index chg_k
  task automatic capture(input int chg_k, input logic [1:0] chg_mode);
    for (int k = 0; k < FRAME; k++) begin
      cap_rgb[k] = {b_a, g_a, r_a};
      cap_col[k] = col_a;
      cap_row[k] = row_a;
      cap_rdn[k] = rdn_a;
      cap_hs[k]  = hs_a;
      cap_vs[k]  = vs_a;
      cap_de[k]  = de_a;
      cap_fs[k]  = fs_a;
      cap_ls[k]  = ls_a;
      if (k == chg_k) mode_a = chg_mode;
      @(negedge clk);
    end
  endtask

  task automatic tally();
    n_hs_lo = 0; n_vs_lo = 0; n_de = 0; n_ls = 0; n_fs = 0; n_rdn_lo = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (cap_hs[k] === 1'b0) n_hs_lo++;
      if (cap_vs[k] === 1'b0) n_vs_lo++;
      if (cap_de[k] === 1'b1) n_de++;
      if (cap_ls[k] === 1'b1) n_ls++;
      if (cap_fs[k] === 1'b1) n_fs++;
      if (cap_rdn[k] === 1'b0) n_rdn_lo++;
    end
  endtask

  initial begin
    clrn   = 1'b0;
    mode_a = 2'd0;
    fill_a = 12'h000;
    mode_b = 2'd0;
    fill_b = 12'h000;
    d_in_b = 12'h3C7;
    repeat (4) @(negedge clk);

    // Reset state
    chk("rst_hs", 32'(hs_a), 32'd1);
    chk("rst_vs", 32'(vs_a), 32'd1);
    chk("rst_rdn", 32'(rdn_a), 32'd1);
    chk("rst_de", 32'(de_a), 32'd0);
    chk("rst_rgb", 32'({b_a, g_a, r_a}), 32'h000);
    chk("rst_fs", 32'(fs_a), 32'd0);
    chk("rst_ls", 32'(ls_a), 32'd0);
    chk("rst_col", 32'(col_a), 32'd0);
    chk("rst_row", 32'(row_a), 32'd0);
    chk("rst_hs_b", 32'(hs_b), 32'd0);
    chk("rst_vs_b", 32'(vs_b), 32'd0);
    clrn = 1'b1;
    wait_fs(10, steps);
    chk("fs_latency", 32'(steps), 32'd2);

    // Frame 1: framebuffer mode, timing counts and pixel data
    capture(1500, 2'd1);
    tally();
    chk("f1_hs_lo", 32'(n_hs_lo), 32'd192);
    chk("f1_vs_lo", 32'(n_vs_lo), 32'd96);
    chk("f1_de", 32'(n_de), 32'd768);
    chk("f1_ls", 32'(n_ls), 32'd24);
    chk("f1_fs", 32'(n_fs), 32'd1);
    chk("f1_rdn_lo", 32'(n_rdn_lo), 32'd768);
    chk("f1_hs_k0", 32'(cap_hs[0]), 32'd0);
    chk("f1_hs_k5", 32'(cap_hs[5]), 32'd0);
    chk("f1_hs_k6", 32'(cap_hs[6]), 32'd1);
    chk("f1_vs_k95", 32'(cap_vs[95]), 32'd0);
    chk("f1_vs_k96", 32'(cap_vs[96]), 32'd1);
    chk("f1_rdn_k298", 32'(cap_rdn[298]), 32'd1);
    chk("f1_rdn_k299", 32'(cap_rdn[299]), 32'd0);
    chk("f1_col_k299", 32'(cap_col[299]), 32'd0);
    chk("f1_row_k299", 32'(cap_row[299]), 32'd0);
    chk("f1_de_k299", 32'(cap_de[299]), 32'd0);
    chk("f1_de_k300", 32'(cap_de[300]), 32'd1);
    chk("f1_ls_k300", 32'(cap_ls[300]), 32'd1);
    chk("f1_ls_k301", 32'(cap_ls[301]), 32'd0);
    chk("f1_rgb_k300", 32'(cap_rgb[300]), 32'h000);
    chk("f1_rgb_k301", 32'(cap_rgb[301]), 32'h101);
    chk("f1_rgb_r5c17", 32'(cap_rgb[557]), 32'h151);
    chk("f1_de_k331", 32'(cap_de[331]), 32'd1);
    chk("f1_de_k332", 32'(cap_de[332]), 32'd0);
    chk("f1_de_lastrow", 32'(cap_de[1404]), 32'd1);
    chk("f1_de_fporch", 32'(cap_de[1452]), 32'd0);
    chk("f1_fs_wrap", 32'(fs_a), 32'd1);

    // Frame 2: colour bars, width 4
    capture(1500, 2'd0);
    tally();
    chk("f2_rdn_lo", 32'(n_rdn_lo), 32'd0);
    chk("f2_white_c0", 32'(cap_rgb[300]), 32'hFFF);
    chk("f2_white_c3", 32'(cap_rgb[303]), 32'hFFF);
    chk("f2_yellow_c4", 32'(cap_rgb[304]), 32'h0FF);
    chk("f2_cyan_c8", 32'(cap_rgb[308]), 32'hFF0);
    chk("f2_red_c20", 32'(cap_rgb[320]), 32'h00F);
    chk("f2_black_c28", 32'(cap_rgb[328]), 32'h000);
    chk("f2_black_c31_de", 32'(cap_de[331]), 32'd1);
    chk("f2_magenta_r10c16", 32'(cap_rgb[796]), 32'hF0F);
    chk("f2_fs_wrap", 32'(fs_a), 32'd1);

    // Frame 3: mode switched to fill mid-frame; still framebuffer data
    fill_a = 12'h0A5;
    capture(700, 2'd3);
    tally();
    chk("f3_rdn_lo", 32'(n_rdn_lo), 32'd768);
    chk("f3_rgb_r5c17", 32'(cap_rgb[557]), 32'h151);
    chk("f3_rgb_r10c20", 32'(cap_rgb[800]), 32'h4A4);
    chk("f3_fs_wrap", 32'(fs_a), 32'd1);

    // Frame 4: solid fill takes effect
    capture(1500, 2'd2);
    tally();
    chk("f4_rdn_lo", 32'(n_rdn_lo), 32'd0);
    chk("f4_rgb_k299", 32'(cap_rgb[299]), 32'h000);
    chk("f4_fill_k300", 32'(cap_rgb[300]), 32'h0A5);
    chk("f4_fill_k1404", 32'(cap_rgb[1404]), 32'h0A5);
    chk("f4_fs_wrap", 32'(fs_a), 32'd1);

    // Frame 5: grid
    capture(1500, 2'd0);
    tally();
    chk("f5_rdn_lo", 32'(n_rdn_lo), 32'd0);
    chk("f5_grid_r0c5", 32'(cap_rgb[305]), 32'hFFF);
    chk("f5_grid_r1c1", 32'(cap_rgb[349]), 32'h000);
    chk("f5_grid_r1c16", 32'(cap_rgb[364]), 32'hFFF);
    chk("f5_grid_r1c31", 32'(cap_rgb[379]), 32'hFFF);
    chk("f5_grid_r23c5", 32'(cap_rgb[1409]), 32'hFFF);
    chk("f5_grid_r3c17", 32'(cap_rgb[461]), 32'h000);
    chk("f5_fs_wrap", 32'(fs_a), 32'd1);

    // Frame 6: reset in the middle of an active line
    repeat (557) @(negedge clk);
    chk("f6_de_pre", 32'(de_a), 32'd1);
    chk("f6_rgb_pre", 32'({b_a, g_a, r_a}), 32'h151);
    clrn = 1'b0;
    @(negedge clk);
    chk("mid_rst_hs", 32'(hs_a), 32'd1);
    chk("mid_rst_vs", 32'(vs_a), 32'd1);
    chk("mid_rst_rdn", 32'(rdn_a), 32'd1);
    chk("mid_rst_de", 32'(de_a), 32'd0);
    chk("mid_rst_rgb", 32'({b_a, g_a, r_a}), 32'h000);
    chk("mid_rst_ls", 32'(ls_a), 32'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    wait_fs(10, steps);
    chk("mid_rst_fs_latency", 32'(steps), 32'd2);
    chk("mid_rst_hs_k0", 32'(hs_a), 32'd0);
    capture(-1, 2'd0);
    tally();
    chk("f7_fs_count", 32'(n_fs), 32'd1);
    chk("f7_de", 32'(n_de), 32'd768);
    chk("f7_hs_lo", 32'(n_hs_lo), 32'd192);
    chk("f7_rgb_r5c17", 32'(cap_rgb[557]), 32'h151);
    chk("f7_fs_wrap", 32'(fs_a), 32'd1);

    // Instance B: active-high sync polarity
    steps = 0;
    while (fs_b !== 1'b1 && steps < 400) begin
      @(negedge clk);
      steps++;
    end
    chk("b_fs_seen", 32'(fs_b), 32'd1);
    bh = 0; bv = 0; bd = 0; bl = 0;
    for (int k = 0; k < FRAME_B; k++) begin
      if (hs_b === 1'b1) bh++;
      if (vs_b === 1'b1) bv++;
      if (de_b === 1'b1) bd++;
      if (ls_b === 1'b1) bl++;
      if (k == 0)   chk("b_hs_k0", 32'(hs_b), 32'd1);
      if (k == 3)   chk("b_hs_k3", 32'(hs_b), 32'd0);
      if (k == 49)  chk("b_vs_k49", 32'(vs_b), 32'd1);
      if (k == 50)  chk("b_vs_k50", 32'(vs_b), 32'd0);
      if (k == 131) begin
        chk("b_col_k131", 32'(col_b), 32'd0);
        chk("b_row_k131", 32'(row_b), 32'd0);
        chk("b_rdn_k131", 32'(rdn_b), 32'd0);
        chk("b_rgb_k131", 32'({b_b, g_b, r_b}), 32'h000);
      end
      if (k == 132) begin
        chk("b_de_k132", 32'(de_b), 32'd1);
        chk("b_ls_k132", 32'(ls_b), 32'd1);
        chk("b_rgb_k132", 32'({b_b, g_b, r_b}), 32'h3C7);
      end
      @(negedge clk);
    end
    chk("b_hs_hi", 32'(bh), 32'd42);
    chk("b_vs_hi", 32'(bv), 32'd50);
    chk("b_de", 32'(bd), 32'd128);
    chk("b_ls", 32'(bl), 32'd8);
    chk("b_fs_wrap", 32'(fs_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/vgac_param.md
Name: vgac_param

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates horizontal and vertical timing for any mode set by parameters, using configurable sync polarity and colour depth.
- Issues framebuffer read addresses and registers pixel data from d_in onto the RGB pins.
- Adds a data-enable output, frame/line start strobes, and built-in test-pattern modes.
- Sits between the framebuffer/sprite compositor and the VGA connector.

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of hs (0 = active-low).
- VS_POL, 0: asserted level of vs (0 = active-low).
- CW, 4: bits per colour channel.
- AW, 10: width of the counters and address outputs. Must satisfy 2^AW > H_TOTAL and 2^AW > V_TOTAL.

Ports:
- vga_clk, in, 1: pixel clock.
- clrn, in, 1: reset, synchronous, active-low.
- mode, in, 2: pattern select. 0 = framebuffer, 1 = colour bars, 2 = grid, 3 = solid fill.
- fill, in, 3*CW: solid fill colour, packed {b,g,r}.
- d_in, in, 3*CW: pixel data, packed {b,g,r} with r in the LSBs.
- row_addr, out, AW: pixel row being fetched.
- col_addr, out, AW: pixel column being fetched.
- rdn, out, 1: read strobe, active-low.
- r, out, CW: red channel.
- g, out, CW: green channel.
- b, out, CW: blue channel.
- hs, out, 1: horizontal sync.
- vs, out, 1: vertical sync.
- de, out, 1: data enable, high while active video is on the pins.
- frame_start, out, 1: one-cycle pulse at the start of each frame.
- line_start, out, 1: one-cycle pulse at the start of each active line.

Behaviour:
- Derived constants: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Line order and frame order are both sync, back porch, active, front porch.
- h_cnt counts 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments only when h_cnt == H_TOTAL-1, and wraps from V_TOTAL-1 to 0 at that same edge.
- Reset (clrn low at the vga_clk edge) forces:
  - h_cnt = 0, v_cnt = 0;
  - row_addr = 0, col_addr = 0;
  - rdn = 1;
  - r = g = b = 0;
  - hs = !HS_POL, vs = !VS_POL;
  - de = 0, frame_start = 0, line_start = 0;
  - the latched mode = 0.
- Reset mid-line: the next line restarts cleanly from h_cnt = 0. No partial pixel is driven.
- Active region: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
- Stage 1 registers, one cycle after the counters:
  - col_addr = h_cnt-(H_SYNC+H_BP), truncated to AW bits;
  - row_addr = v_cnt-(V_SYNC+V_BP), truncated to AW bits;
  - rdn = !(active && latched_mode == 0);
  - internal delayed copies of active, hsync and vsync.
- Outside the active region the address values are don't-care, but they are still computed as above.
- d_in is valid during the cycle in which rdn is low, and is sampled at the following edge.
- Stage 2 registers, two cycles after the counters:
  - hs = (h_cnt < H_SYNC) ? HS_POL : !HS_POL, delayed two cycles;
  - vs = (v_cnt < V_SYNC) ? VS_POL : !VS_POL, delayed two cycles;
  - de = active, delayed two cycles;
  - r,g,b = 0 when de is low, otherwise the pixel source.
- Pixel source by latched mode:
  - 0: d_in.
  - 1: 8 equal vertical bars of width H_ACTIVE/8. Order is white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or 0.
  - 2: white where col_addr[3:0] == 0, row_addr[3:0] == 0, col_addr == H_ACTIVE-1 or row_addr == V_ACTIVE-1; black elsewhere.
  - 3: fill.
- In modes 1-3, rdn stays high for the whole frame.
- mode is sampled only when h_cnt == 0 and v_cnt == 0. Changing mode mid-frame has no effect until the next frame.
- frame_start is high for exactly one cycle: the stage-2 cycle corresponding to h_cnt == 0, v_cnt == 0.
- line_start is high for exactly one cycle: the stage-2 cycle of the first active pixel of each active line. It is aligned with de rising.
- When both strobes coincide with a counter wrap, each still fires once per event.
- Total latency from counter to pins is 2 cycles, identical for sync, de and colour.

Test Plan:
- Defaults, 2 frames:
  - hs period 800 cycles, asserted (low) 96 cycles;
  - vs period 420000 cycles, asserted (low) 2 lines = 1600 cycles;
  - de high 640 cycles per line on 480 lines per frame.
- mode=0, d_in = {col_addr[3:0], row_addr[3:0], col_addr[3:0]}:
  - first de pixel has r=0, g=0, b=0 with col_addr=0 one cycle earlier;
  - pixel at (row 5, col 17) outputs b=1, g=5, r=1;
  - rdn low exactly 640x480 cycles per frame.
- mode=1:
  - col 0..79 is white (r=g=b=F);
  - col 80..159 is yellow (r=F, g=F, b=0);
  - col 560..639 is black;
  - rdn never low.
- mode switched 0->3 mid-frame, fill=12'h0A5: pins keep showing d_in until the next frame_start, then show r=5, g=A, b=0.
- clrn held low for 3 cycles at h_cnt=400, v_cnt=200:
  - outputs take their reset values on the next edge, including hs=1, vs=1 and rdn=1;
  - after release, frame_start fires once and the first hs assertion occurs at stage-2 cycle 0.
- HS_POL=1, VS_POL=1, H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, V_ACTIVE=600, V_FP=1, V_SYNC=4, V_BP=23, AW=11:
  - hs high for 128 of 1056 cycles;
  - vs high for 4 of 628 lines;
  - de high for 800 cycles per line.
